// File: rtl/studio_mem_arbiter_if.sv
// rtl/studio_mem_arbiter_if.sv - single-port byte-wide BRAM bus between the Studio II arbiter and its RAM
interface studio_mem_arbiter_if;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/studio_mem_arbiter.sv
// rtl/studio_mem_arbiter.sv - Studio II BRAM arbiter (DMA > download > CPU) and CPU hold sequencer
// Optional download checksum built only when STUDIO_DL_CHECKSUM_EN is defined.
module studio_mem_arbiter #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [7:0]  CART_INDEX  = 8'd1,
    parameter logic [11:0] ROM_SIZE    = 12'h400,
    parameter logic [11:0] CART_BASE   = 12'h400,
    parameter logic [11:0] CART_SIZE   = 12'h400,
    parameter logic [11:0] RAM_BASE    = 12'h800,
    parameter int          HOLD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download_i,
    input  logic [7:0]  ioctl_index_i,
    input  logic        ioctl_wr_i,
    input  logic [24:0] ioctl_addr_i,
    input  logic [7:0]  ioctl_dout_i,
    output logic        ioctl_wait_o,
    input  logic        dma_req_i,
    input  logic [11:0] dma_addr_i,
    output logic        dma_ack_o,
    output logic [7:0]  dma_dout_o,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [11:0] cpu_addr_i,
    input  logic [7:0]  cpu_din_i,
    output logic        cpu_ack_o,
    output logic [7:0]  cpu_dout_o,
    output logic        cpu_halt_o,
    studio_mem_arbiter_if.master mem,
    output logic [7:0]  dl_checksum_o
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cpu_run;

    logic            buf_valid_q, buf_valid_d;
    logic [11:0]     buf_addr_q, buf_addr_d;
    logic [7:0]      buf_data_q, buf_data_d;

    logic            map_rom, map_cart, dl_accept;
    logic [11:0]     map_addr;

    logic            gnt_dma, gnt_dl, gnt_cpu;
    logic            s1_dma_q, s1_dl_q, s1_cpu_q;
    logic            dma_ack_q, cpu_ack_q;

    logic [11:0]     mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_din_q, mem_din_d;

    // Sequencer: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= HOLD_RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sequencer: next state; a download always wins over finishing the hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_HOLD: begin
                if (ioctl_download_i) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_LOAD: begin
                if (!ioctl_download_i && !buf_valid_q) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_RELOAD;
                end
            end
            ST_RUN: begin
                if (ioctl_download_i) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_RELOAD;
            end
        endcase
    end

    // Sequencer: outputs
    always_comb begin
        cpu_run    = (state_q == ST_RUN);
        cpu_halt_o = !cpu_run;
    end

    // Image byte mapping; unmapped strobes never touch the buffer
    always_comb begin
        map_rom   = (ioctl_index_i == ROM_INDEX)  && (ioctl_addr_i < 25'(ROM_SIZE));
        map_cart  = (ioctl_index_i == CART_INDEX) && (ioctl_addr_i < 25'(CART_SIZE));
        map_addr  = map_rom ? ioctl_addr_i[11:0] : (CART_BASE + ioctl_addr_i[11:0]);
        dl_accept = ioctl_wr_i && !buf_valid_q && (map_rom || map_cart);
    end

    // A requester whose access was granted last cycle is masked for one cycle
    always_comb begin
        gnt_dma = dma_req_i && !s1_dma_q;
        gnt_dl  = !gnt_dma && buf_valid_q && !s1_dl_q;
        gnt_cpu = !gnt_dma && !gnt_dl && cpu_req_i && cpu_run && !s1_cpu_q;
    end

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        if (gnt_dl) begin
            buf_valid_d = 1'b0;
        end else if (dl_accept) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = map_addr;
            buf_data_d  = ioctl_dout_i;
        end
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        if (gnt_dma) begin
            mem_addr_d = dma_addr_i;
        end else if (gnt_dl) begin
            mem_addr_d = buf_addr_q;
            mem_we_d   = 1'b1;
            mem_din_d  = buf_data_q;
        end else if (gnt_cpu) begin
            mem_addr_d = cpu_addr_i;
            mem_we_d   = cpu_we_i && (cpu_addr_i >= RAM_BASE);
            mem_din_d  = cpu_din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 12'h000;
            buf_data_q  <= 8'h00;
            mem_addr_q  <= 12'h000;
            mem_we_q    <= 1'b0;
            mem_din_q   <= 8'h00;
            s1_dma_q    <= 1'b0;
            s1_dl_q     <= 1'b0;
            s1_cpu_q    <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_din_q   <= mem_din_d;
            s1_dma_q    <= gnt_dma;
            s1_dl_q     <= gnt_dl;
            s1_cpu_q    <= gnt_cpu;
            dma_ack_q   <= s1_dma_q;
            cpu_ack_q   <= s1_cpu_q;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_din  = mem_din_q;

    // BRAM read data is valid in the ack cycle; outside it the data ports read zero
    assign ioctl_wait_o = buf_valid_q;
    assign dma_ack_o    = dma_ack_q;
    assign cpu_ack_o    = cpu_ack_q;
    assign dma_dout_o   = dma_ack_q ? mem.mem_dout : 8'h00;
    assign cpu_dout_o   = cpu_ack_q ? mem.mem_dout : 8'h00;

`ifdef STUDIO_DL_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       dl_prev_q;

    always_comb begin
        sum_d = (ioctl_download_i && !dl_prev_q) ? 8'h00 : sum_q;
        if (dl_accept) begin
            sum_d = sum_d + ioctl_dout_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q     <= 8'h00;
            dl_prev_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            dl_prev_q <= ioctl_download_i;
        end
    end

    assign dl_checksum_o = sum_q;
`else
    assign dl_checksum_o = 8'h00;
`endif

endmodule

// File: tb/tb_studio_mem_arbiter.sv
// tb/tb_studio_mem_arbiter.sv - directed bench for studio_mem_arbiter with a cycle-indexed event model
module tb_studio_mem_arbiter;

    localparam int HOLD = 64;
    localparam int NCYC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dl = 1'b0;
    logic [7:0]  idx = 8'd0;
    logic        wr = 1'b0;
    logic [24:0] iaddr = '0;
    logic [7:0]  idata = 8'h00;
    logic        ioctl_wait;
    logic        dma_req = 1'b0;
    logic [11:0] dma_addr = 12'h000;
    logic        dma_ack;
    logic [7:0]  dma_dout;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = 12'h000;
    logic [7:0]  cpu_din = 8'h00;
    logic        cpu_ack;
    logic [7:0]  cpu_dout;
    logic        cpu_halt;
    logic [7:0]  dl_checksum;

    studio_mem_arbiter_if mbus ();

    studio_mem_arbiter dut (
        .clk              (clk),
        .reset            (rst),
        .ioctl_download_i (dl),
        .ioctl_index_i    (idx),
        .ioctl_wr_i       (wr),
        .ioctl_addr_i     (iaddr),
        .ioctl_dout_i     (idata),
        .ioctl_wait_o     (ioctl_wait),
        .dma_req_i        (dma_req),
        .dma_addr_i       (dma_addr),
        .dma_ack_o        (dma_ack),
        .dma_dout_o       (dma_dout),
        .cpu_req_i        (cpu_req),
        .cpu_we_i         (cpu_we),
        .cpu_addr_i       (cpu_addr),
        .cpu_din_i        (cpu_din),
        .cpu_ack_o        (cpu_ack),
        .cpu_dout_o       (cpu_dout),
        .cpu_halt_o       (cpu_halt),
        .mem              (mbus.master),
        .dl_checksum_o    (dl_checksum)
    );

    always #5 clk = ~clk;

    // Byte-wide BRAM with one-cycle registered read
    logic [7:0] bram [NCYC];
    logic [7:0] sh   [NCYC];
    initial begin
        for (int i = 0; i < NCYC; i++) begin
            bram[i] = 8'(i) ^ 8'h5C;
            sh[i]   = 8'(i) ^ 8'h5C;
        end
    end
    always @(posedge clk) begin
        if (mbus.mem_we) bram[mbus.mem_addr] <= mbus.mem_din;
        mbus.mem_dout <= bram[mbus.mem_addr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected bus/ack events per cycle, filled in when the grant is decided
    bit          e_acc [NCYC];
    bit          e_we  [NCYC];
    logic [11:0] e_addr[NCYC];
    logic [7:0]  e_din [NCYC];
    bit          e_dack[NCYC];
    logic [7:0]  e_ddat[NCYC];
    bit          e_cack[NCYC];
    bit          e_crd [NCYC];
    logic [7:0]  e_cdat[NCYC];

    bit          m_buf_v, m_last_dma, m_last_cpu, m_loading, m_prev_dl;
    logic [11:0] m_buf_a;
    logic [7:0]  m_buf_d, m_sum;
    int          m_release;
    bit          x_wait, x_halt;

    task automatic clear_slot(input int c);
        e_acc[c] = 0; e_we[c] = 0; e_dack[c] = 0; e_cack[c] = 0; e_crd[c] = 0;
    endtask

    task automatic model_step();
        int c;
        bit running, g_dma, g_dl, g_cpu, mapped;
        logic [11:0] ma;
        c = cyc;
        if (rst) begin
            m_buf_v = 0; m_last_dma = 0; m_last_cpu = 0; m_loading = 0;
            m_prev_dl = 0; m_sum = 8'h00; m_release = c + 1 + HOLD;
            clear_slot(c + 1);
            clear_slot(c + 2);
        end else begin
            running = !m_loading && (c >= m_release);
            g_dma = dma_req && !m_last_dma;
            g_dl  = !g_dma && m_buf_v;
            g_cpu = !g_dma && !g_dl && cpu_req && running && !m_last_cpu;
            if (g_dma) begin
                e_acc[c+1] = 1; e_addr[c+1] = dma_addr;
                e_dack[c+2] = 1; e_ddat[c+2] = sh[dma_addr];
            end
            if (g_dl) begin
                e_acc[c+1] = 1; e_addr[c+1] = m_buf_a; e_we[c+1] = 1; e_din[c+1] = m_buf_d;
                sh[m_buf_a] = m_buf_d;
            end
            if (g_cpu) begin
                e_acc[c+1] = 1; e_addr[c+1] = cpu_addr;
                e_cack[c+2] = 1; e_crd[c+2] = !cpu_we; e_cdat[c+2] = sh[cpu_addr];
                if (cpu_we && cpu_addr >= 12'h800) begin
                    e_we[c+1] = 1; e_din[c+1] = cpu_din; sh[cpu_addr] = cpu_din;
                end
            end
            if (m_loading) begin
                if (!dl && !m_buf_v) begin
                    m_loading = 0;
                    m_release = c + 1 + HOLD;
                end
            end else if (dl) begin
                m_loading = 1;
            end
            mapped = 0;
            ma = 12'h000;
            if (idx == 8'd0 && iaddr < 25'h400) begin
                mapped = 1; ma = iaddr[11:0];
            end else if (idx == 8'd1 && iaddr < 25'h400) begin
                mapped = 1; ma = 12'h400 + iaddr[11:0];
            end
            if (dl && !m_prev_dl) m_sum = 8'h00;
            if (wr && !m_buf_v && mapped) m_sum = m_sum + idata;
            if (g_dl) begin
                m_buf_v = 0;
            end else if (wr && !m_buf_v && mapped) begin
                m_buf_v = 1; m_buf_a = ma; m_buf_d = idata;
            end
            m_last_dma = g_dma;
            m_last_cpu = g_cpu;
            m_prev_dl  = dl;
        end
        x_wait = m_buf_v;
        x_halt = !(!m_loading && (c + 1 >= m_release));
        cyc = cyc + 1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("ioctl_wait", ioctl_wait, x_wait);
            check("cpu_halt", cpu_halt, x_halt);
            check("mem_we", mbus.mem_we, e_we[cyc]);
            if (e_acc[cyc]) check("mem_addr", mbus.mem_addr, e_addr[cyc]);
            if (e_we[cyc])  check("mem_din", mbus.mem_din, e_din[cyc]);
            check("dma_ack", dma_ack, e_dack[cyc]);
            if (e_dack[cyc]) check("dma_dout", dma_dout, e_ddat[cyc]);
            check("cpu_ack", cpu_ack, e_cack[cyc]);
            if (e_cack[cyc] && e_crd[cyc]) check("cpu_dout", cpu_dout, e_cdat[cyc]);
`ifdef STUDIO_DL_CHECKSUM_EN
            check("dl_checksum", dl_checksum, m_sum);
`else
            check("dl_checksum", dl_checksum, 8'h00);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic dl_byte(input logic [7:0] ix, input logic [24:0] off, input logic [7:0] d);
        int n;
        n = 0;
        while (ioctl_wait && n < 50) begin n++; step(); end
        check("dl_wait_bound", n < 50, 1);
        idx = ix; iaddr = off; idata = d; wr = 1'b1;
        step();
        wr = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int n, nack, k;
        // Reset state
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("rst_halt", cpu_halt, 1);
        check("rst_wait", ioctl_wait, 0);
        check("rst_mem_we", mbus.mem_we, 0);
        check("rst_mem_addr", mbus.mem_addr, 0);
        check("rst_mem_din", mbus.mem_din, 0);
        check("rst_dma_dout", dma_dout, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_checksum", dl_checksum, 0);
        rst = 1'b0;
        n = 0;
        while (cpu_halt && n < 200) begin n++; step(); end
        check("hold_len", n, HOLD);

        // Cartridge download plus dropped strobes
        dl = 1'b1;
        step();
        dl_byte(8'd1, 25'h0, 8'h11);
        dl_byte(8'd1, 25'h1, 8'h22);
        dl_byte(8'd5, 25'h2, 8'h77);
        check("drop_idx_wait", ioctl_wait, 0);
        dl_byte(8'd1, 25'h400, 8'h99);
        check("drop_off_wait", ioctl_wait, 0);
        dl = 1'b0;
        repeat (3) step();
        check("cart_byte0", bram[12'h400], 8'h11);
        check("cart_byte1", bram[12'h401], 8'h22);
        check("cart_no_spill", bram[12'h002], 8'h02 ^ 8'h5C);
`ifdef STUDIO_DL_CHECKSUM_EN
        check("cart_checksum", dl_checksum, 8'h33);
`endif

        // Continuous DMA interleaved with a ROM download
        dl = 1'b1; idx = 8'd0; dma_req = 1'b1; dma_addr = 12'h020;
        nack = 0; k = 0;
        for (int i = 0; i < 24; i++) begin
            if (dma_ack) nack++;
            if (!ioctl_wait && k < 4) begin
                wr = 1'b1; iaddr = 25'(12'h010 + k); idata = 8'(8'hC0 + k); k++;
            end else begin
                wr = 1'b0;
            end
            step();
        end
        wr = 1'b0; dma_req = 1'b0; dl = 1'b0;
        repeat (3) step();
        check("dma_ack_count", nack, 11);
        check("rom_bytes_sent", k, 4);
        check("rom_byte0", bram[12'h010], 8'hC0);
        check("rom_byte3", bram[12'h013], 8'hC3);

        // CPU accesses in RUN
        n = 0;
        while (cpu_halt && n < 200) begin n++; step(); end
        check("run_bound", n < 200, 1);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h100; cpu_din = 8'hA5;
        step();
        cpu_req = 1'b0;
        check("rom_wr_no_we", mbus.mem_we, 0);
        step();
        check("rom_wr_ack", cpu_ack, 1);
        cpu_req = 1'b1; cpu_we = 1'b0;
        step();
        cpu_req = 1'b0;
        step();
        check("rom_rd_ack", cpu_ack, 1);
        check("rom_rd_data", cpu_dout, 8'h5C);
        step();

        // Simultaneous CPU write and DMA read to the same RAM byte
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h810; cpu_din = 8'h5A;
        dma_req = 1'b1; dma_addr = 12'h810;
        step();
        dma_req = 1'b0;
        step();
        cpu_req = 1'b0;
        check("race_dma_ack", dma_ack, 1);
        check("race_dma_old", dma_dout, 8'h4C);
        check("race_cpu_wait", cpu_ack, 0);
        step();
        check("race_cpu_ack", cpu_ack, 1);
        dma_req = 1'b1;
        step();
        dma_req = 1'b0;
        step();
        check("race_dma_new", dma_dout, 8'h5A);
        step();

        // Reset with a CPU read in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h810;
        step();
        cpu_req = 1'b0; rst = 1'b1;
        step();
        check("rst_flight_ack", cpu_ack, 0);
        check("rst_flight_halt", cpu_halt, 1);
        step();
        check("rst_flight_ack2", cpu_ack, 0);
        rst = 1'b0;
        repeat (5) step();
        check("rst_flight_hold", cpu_halt, 1);

        // Reset with download high goes straight to LOAD and stays halted
        rst = 1'b1; dl = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (HOLD + 10) step();
        check("rst_dl_load", cpu_halt, 1);
        dl = 1'b0;
        repeat (HOLD + 4) step();
        check("load_exit_run", cpu_halt, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule

// File: doc/studio_mem_arbiter.md
# studio_mem_arbiter

Single-port memory arbiter and load sequencer for the RCA Studio II core. Shares one 4 KiB byte-wide block RAM between three requesters: CDP1861 video DMA, the ioctl ROM/cartridge download path and the CDP1802 CPU. It also holds the CPU halted from reset, during a download and for a fixed settle period after one.

## Interface
Parameters:
- `ROM_INDEX`, 0: ioctl_index value for the BIOS image.
- `CART_INDEX`, 1: ioctl_index value for a cartridge image.
- `ROM_SIZE`, 12'h400: BIOS image byte limit, loaded at 0x000.
- `CART_BASE`, 12'h400: memory base address for the cartridge image.
- `CART_SIZE`, 12'h400: cartridge image byte limit.
- `RAM_BASE`, 12'h800: first CPU-writable address; CPU writes below it are discarded.
- `HOLD_CYCLES`, 64: post-reset and post-download CPU halt length (≥2).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ioctl_download`  in  1  download window.
- `ioctl_index`  in  8  image selector.
- `ioctl_wr`  in  1  one-cycle byte strobe.
- `ioctl_addr`  in  25  byte offset within the image.
- `ioctl_dout`  in  8  download byte.
- `ioctl_wait`  out  1  back-pressure to loader.
- `dma_req`, `dma_addr[11:0]`  in  video fetch request and address.
- `dma_ack`  out  1  read-data-valid pulse.
- `dma_dout`  out  8  read data.
- `cpu_req`, `cpu_we`  in  1 each  CPU request and write enable.
- `cpu_addr`  in  12  CPU address.
- `cpu_din`  in  8  CPU write data.
- `cpu_ack`  out  1  completion pulse.
- `cpu_dout`  out  8  read data.
- `cpu_halt`  out  1  holds the 1802 in reset.
- `mem_addr`  out  12  BRAM address.
- `mem_we`  out  1  BRAM write enable.
- `mem_din`  out  8  BRAM write data.
- `mem_dout`  in  8  BRAM read data, one-cycle registered read.
- `dl_checksum`  out  8  see Configuration.

## Operation
- Sequencer states: HOLD, LOAD, RUN.
  - Reset enters HOLD with the counter set to HOLD_CYCLES.
  - HOLD: counter decrements each cycle. At 0, go to RUN. If `ioctl_download` is high, go to LOAD, which takes precedence.
  - RUN: `ioctl_download` high → LOAD.
  - LOAD: `ioctl_download` low and write buffer empty → HOLD, counter reloaded.
  - `cpu_halt` = 1 in HOLD and LOAD; 0 only in RUN.
- Download buffer: one entry (addr, data, valid).
  - An `ioctl_wr` pulse while empty captures the byte.
  - The byte is mapped on capture:
    - Index ROM_INDEX with offset < ROM_SIZE → address = offset.
    - Index CART_INDEX with offset < CART_SIZE → address = CART_BASE + offset[11:0].
    - Anything else is dropped: not buffered, no wait.
  - `ioctl_wait` = buffer valid. The loader must not pulse `ioctl_wr` while `ioctl_wait` is high; a strobe in that condition is ignored.
- Fixed priority per cycle: DMA > download buffer > CPU. Exactly one grant per cycle.
  - CPU is granted only in RUN.
  - A requester with an issued-but-unacked access is masked from new grants.
- CPU writes with `cpu_addr` < RAM_BASE: granted and acked, but `mem_we` stays 0.
- Download writes carry no ack. The buffer clears on grant.

## Timing
- Cycle N: `req` sampled and grant decided.
- Cycle N+1: `mem_addr`/`mem_we`/`mem_din` registered outputs present the access.
- Cycle N+2: `mem_dout` valid; the matching `*_ack` pulses for exactly one cycle with `*_dout` = `mem_dout`. Writes also ack at N+2.
- Sustained throughput is one access per cycle. A single requester holding `req` high continuously gets one access every 2 cycles, due to masking.
- A `req` still high in the cycle after its ack is a new request.
- Worst-case CPU latency is unbounded under continuous DMA plus download. DMA latency is always exactly 2.
- Reset values: `ioctl_wait`=0, `dma_ack`=0, `cpu_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `dma_dout`=0, `cpu_dout`=0, `cpu_halt`=1, `dl_checksum`=0.
- Reset mid-access discards in-flight grants (no ack) and the download buffer.
- Reset with `ioctl_download` high enters LOAD on the cycle after reset deasserts.
- Simultaneous `ioctl_wr` and buffer grant in the same cycle: the grant drains the old entry. The new strobe is ignored because `ioctl_wait` was high.

## Configuration
- `STUDIO_DL_CHECKSUM_EN` defined:
  - `dl_checksum` accumulates a modulo-256 sum of every accepted (mapped) download byte.
  - The sum clears on the rising edge of `ioctl_download`.
  - The value holds after LOAD exits.
- Not defined: `dl_checksum` is constant 0 and no accumulator is built.

## Test plan
- Reset, idle inputs: `cpu_halt`=1 for 64 cycles after reset deasserts, then 0; all other outputs stay 0.
- CART_INDEX download of bytes 0x11, 0x22 at offsets 0, 1: `mem_we` writes 0x11@0x400 and 0x22@0x401; index 5 bytes and offset 0x400 are dropped; with the macro defined, `dl_checksum`=0x33.
- `dma_req` continuously high during a download: DMA acks every 2 cycles; `ioctl_wait` rises and the download buffer is granted in DMA's masked cycles; no byte is lost.
- RUN, CPU write 0xA5@0x100, then CPU read 0x100: no `mem_we` for the write; `cpu_ack` at N+2; read returns the ROM value.
- RUN, CPU write 0x5A@0x810 and DMA read 0x810 in the same cycle: DMA is granted first and reads the old value; the CPU ack arrives one cycle later; a subsequent DMA read returns 0x5A.
- Reset asserted with a CPU read in flight: no `cpu_ack`; state HOLD; `cpu_halt`=1.
